dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Shares the single data-bus port (dbus_req_t / dbus_resp_t) among NUM_REQ requesters, e.g. the multicycle load and store stages plus a debug/uncached port.
- Grants one requester at a time using a round-robin pointer.
- Holds a registered copy of the granted request on the downstream bus until the addr_ok/data_ok handshake completes.
- Routes the response back to the owning requester only.

Parameters:
NUM_REQ, 2, number of upstream requesters (legal range 2..4)
IDX_W, $clog2(NUM_REQ), width of the grant index

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ureq  input  NUM_REQ x dbus_req_t  upstream requests (valid, addr, size, strobe, data)
uresp  output  NUM_REQ x dbus_resp_t  upstream responses (addr_ok, data_ok, data)
dreq  output  dbus_req_t  downstream request to the memory/cache side
dresp  input  dbus_resp_t  downstream response
busy  output  1  high while a transaction is owned (state != S_IDLE)
owner  output  IDX_W  index of the current owner; 0 when idle

Behaviour:
- Reset is asynchronous, active-high. While reset is high:
  - state = S_IDLE, rr_ptr = 0, owner = 0, latched request cleared.
  - dreq.valid = 0; all uresp fields = 0; busy = 0.
- States:
  - S_IDLE: no owner.
  - S_ADDR: dreq valid, waiting for dresp.addr_ok.
  - S_DATA: address accepted, waiting for dresp.data_ok.
- S_IDLE arbitration:
  - Scan ureq[i].valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first valid index wins. Register its whole request and its index into owner, then go to S_ADDR.
  - If no requester is valid, stay in S_IDLE.
  - Arbitration costs one bubble: a request visible in cycle t appears on dreq in cycle t+1.
- S_ADDR:
  - dreq = latched request with valid = 1. The request is stable even if ureq changes.
  - dresp.addr_ok && dresp.data_ok in the same cycle: transaction completes; go to S_IDLE.
  - addr_ok only: go to S_DATA.
  - Otherwise stay in S_ADDR.
- S_DATA:
  - dreq.valid = 1 with the same latched fields. Requesters hold valid until data_ok.
  - On dresp.data_ok: go to S_IDLE.
- Response routing:
  - uresp[owner] = dresp combinationally while busy.
  - In S_DATA, uresp[owner].addr_ok is held at 1, so requesters waiting on address acceptance still see it.
  - Every non-owner port gets addr_ok = 0, data_ok = 0, data = 0.
  - In S_IDLE all uresp fields are 0.
- Completion: rr_ptr <= owner + 1, wrapping to 0 past NUM_REQ-1. This gives round-robin fairness; a requester never waits more than NUM_REQ-1 transactions.
- Back-to-back: the earliest next grant is the cycle after completion, so S_IDLE is always visited for one cycle. A requester that completes is therefore sampled at its new request, never its stale one.
- Upstream contract: a requester keeps valid and all fields stable from assertion until its data_ok.
- Requester drop: if the owner's ureq.valid drops mid-transaction, the arbiter still finishes the latched transaction and discards nothing.
- Data passthrough: no width conversion or modification. strobe, size and data are passed through from the latch unchanged; load data comes from dresp.data unchanged.
- Simultaneous requests in S_IDLE: the rr_ptr order decides the winner; all other requesters see no response and wait.
- Reset asserted mid-transaction: immediate return to S_IDLE. dreq.valid drops in the same cycle because reset is asynchronous; no response is delivered.

Test Plan:
- Single requester: NUM_REQ=2, ureq[0] load addr 0x8000_0010, size word. Memory gives addr_ok at cycle 2 and data_ok with data 0xDEADBEEF at cycle 4. Expect dreq.valid from cycle 1, uresp[0].data_ok=1 with 0xDEADBEEF at cycle 4, uresp[1] all-zero throughout, rr_ptr=1 afterwards.
- Contention: both ports valid at cycle 0, rr_ptr=0. Expect port 0 granted first, then port 1 granted in the cycle after port 0's data_ok plus the idle bubble. Repeat 8 rounds with both always valid: grants alternate 0,1,0,1…
- Combined handshake: memory asserts addr_ok and data_ok together. Expect S_ADDR to go directly to S_IDLE, skipping S_DATA, and uresp[owner] to see both oks in that one cycle.
- Stability: owner changes ureq.addr to 0x1234 during S_DATA (a contract violation). Expect dreq.addr to keep the latched 0x8000_0010 until data_ok.
- Reset mid-transaction: assert reset in S_DATA. Expect dreq.valid=0, busy=0, owner=0 immediately. After release, the first grant goes to port 0.
- NUM_REQ=3: ports 1 and 2 valid with rr_ptr=2. Expect the grant order 2, then 1, then 2.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one data-bus port among NUM_REQ requesters.
// The winning request is latched and replayed on dreq until the downstream
// addr_ok/data_ok handshake finishes; the response is steered to its owner.
//
// Handshake semantics: a requester raises ureq.valid and holds every field
// stable until it sees data_ok on its own uresp. Downstream, dreq.valid stays
// high from grant until data_ok; addr_ok accepts the address (it may arrive
// together with data_ok), and data_ok ends the transaction. Nothing is
// accepted or completed in a cycle where the relevant ok is low.

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        ureq [NUM_REQ],
  output dbus_resp_t       uresp [NUM_REQ],
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp,
  output logic             busy,
  output logic [IDX_W-1:0] owner,
  output logic [1:0]       dbg_state,
  output logic [IDX_W-1:0] dbg_rr_ptr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  dbus_req_t        req_q, req_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  dbus_req_t        win_req;

  // Scan requesters starting at the round-robin pointer; first valid wins.
  always_comb begin : arb_scan
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    win_req   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && ureq[cand].valid) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
        win_req   = ureq[cand];
      end
    end
  end

  // Next-state logic: grant from idle, then follow the addr_ok/data_ok handshake.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    req_d    = req_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ADDR;
          owner_d = win_idx;
          req_d   = win_req;
        end
      end
      S_ADDR: begin
        if (dresp.addr_ok && dresp.data_ok) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          owner_d  = '0;
        end else if (dresp.addr_ok) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (dresp.data_ok) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          owner_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = '0;
      end
    endcase
  end

  // State, pointer, owner and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign owner      = owner_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

  // Downstream request replays the latched copy; valid only while owned.
  always_comb begin
    dreq       = req_q;
    dreq.valid = busy;
  end

  // Steer the downstream response to the owner; hold addr_ok once accepted.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      uresp[i] = '0;
      if (busy && (owner_q == IDX_W'(i))) begin
        uresp[i] = dresp;
        if (state_q == S_DATA) begin
          uresp[i].addr_ok = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios with literal expectations, then a
// randomized run checked every cycle against a transaction-level model.

module tb_dbus_arbiter;
  import dbus_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic             clk;
  logic             reset;
  dbus_req_t        ureq [NUM_REQ];
  dbus_resp_t       uresp [NUM_REQ];
  dbus_req_t        dreq;
  dbus_resp_t       dresp;
  logic             busy;
  logic [IDX_W-1:0] owner;
  logic [1:0]       dbg_state;
  logic [IDX_W-1:0] dbg_rr_ptr;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected grant order for the directed part (literal values).
  logic [IDX_W-1:0] exp_q[$];

  dbus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .ureq       (ureq),
    .uresp      (uresp),
    .dreq       (dreq),
    .dresp      (dresp),
    .busy       (busy),
    .owner      (owner),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: who owns the bus (-1 none), whether its address has been
  // accepted, the request captured at grant, and the next-priority index.
  int        m_owner     = -1;
  bit        m_addr_done = 1'b0;
  dbus_req_t m_lat       = '0;
  int        m_ptr       = 0;
  int        done_port   = -1;

  always @(posedge clk or posedge reset) begin : model
    int best;
    int bestd;
    int d;
    if (reset) begin
      m_owner     = -1;
      m_addr_done = 1'b0;
      m_lat       = '0;
      m_ptr       = 0;
      done_port   = -1;
    end else begin
      done_port = -1;
      if (m_owner < 0) begin
        best  = -1;
        bestd = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          d = (i - m_ptr + NUM_REQ) % NUM_REQ;
          if (ureq[i].valid && d < bestd) begin
            best  = i;
            bestd = d;
          end
        end
        if (best >= 0) begin
          if (exp_q.size() > 0) check("grant_order", 80'(best), 80'(exp_q.pop_front()));
          m_owner     = best;
          m_lat       = ureq[best];
          m_addr_done = 1'b0;
        end
      end else if (dresp.data_ok && (dresp.addr_ok || m_addr_done)) begin
        done_port = m_owner;
        m_ptr     = (m_owner + 1) % NUM_REQ;
        m_owner   = -1;
      end else if (dresp.addr_ok) begin
        m_addr_done = 1'b1;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin : cmp
    dbus_req_t  e_req;
    dbus_resp_t e_rsp;
    check("busy", 80'(busy), 80'(m_owner >= 0));
    check("owner", 80'(owner), 80'((m_owner >= 0) ? m_owner : 0));
    check("rr_ptr", 80'(dbg_rr_ptr), 80'(m_ptr));
    check("dreq_valid", 80'(dreq.valid), 80'(m_owner >= 0));
    if (m_owner >= 0) begin
      e_req       = m_lat;
      e_req.valid = 1'b1;
      check("dreq", 80'(dreq), 80'(e_req));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      e_rsp = '0;
      if (i == m_owner) begin
        e_rsp = dresp;
        if (m_addr_done) e_rsp.addr_ok = 1'b1;
      end
      check($sformatf("uresp%0d", i), 80'(uresp[i]), 80'(e_rsp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [2:0] sz,
                         input logic [3:0] st, input logic [31:0] d);
    ureq[p].valid  = 1'b1;
    ureq[p].addr   = a;
    ureq[p].size   = sz;
    ureq[p].strobe = st;
    ureq[p].data   = d;
  endtask

  task automatic rand_req(input int p);
    set_req(p, $urandom() & 32'hFFFF_FFFC, 3'($urandom_range(0, 2)),
            4'($urandom_range(0, 15)), $urandom());
  endtask

  // Wait (bounded) for a grant, check its owner, then run addr_ok followed by
  // data_ok. Returns at the start of the idle cycle with the owner refreshed.
  task automatic serve(input int exp_owner, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_granted"}, 80'(busy), 80'(1));
    check({nm, "_owner"}, 80'(owner), 80'(exp_owner));
    tick();
    dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
    tick();
    dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: $urandom()};
    tick();
    dresp = '0;
    ureq[exp_owner].addr = 32'h8000_0000 | ($urandom() & 32'h0000_FFFC);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    dresp = '0;
    for (int i = 0; i < NUM_REQ; i++) ureq[i] = '0;
    exp_q = '{0, 1, 0, 2, 0, 1, 0, 1, 0, 1, 0, 1, 2, 1, 2};

    // Reset state
    @(negedge clk);
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_owner", 80'(owner), 80'(0));
    check("rst_dreq_valid", 80'(dreq.valid), 80'(0));
    check("rst_uresp0", 80'(uresp[0]), 80'(0));
    check("rst_rr_ptr", 80'(dbg_rr_ptr), 80'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Single requester load on port 0
    set_req(0, 32'h8000_0010, 3'd2, 4'h0, 32'h0);
    @(negedge clk);
    check("t1_c0_idle", 80'(dreq.valid), 80'(0));
    tick();
    @(negedge clk);
    check("t1_c1_valid", 80'(dreq.valid), 80'(1));
    check("t1_c1_addr", 80'(dreq.addr), 80'(32'h8000_0010));
    tick();
    dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
    @(negedge clk);
    check("t1_c2_addr_ok", 80'(uresp[0].addr_ok), 80'(1));
    tick();
    dresp = '0;
    @(negedge clk);
    check("t1_c3_addr_ok_held", 80'(uresp[0].addr_ok), 80'(1));
    check("t1_c3_data_ok", 80'(uresp[0].data_ok), 80'(0));
    tick();
    dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hDEAD_BEEF};
    @(negedge clk);
    check("t1_c4_data_ok", 80'(uresp[0].data_ok), 80'(1));
    check("t1_c4_data", 80'(uresp[0].data), 80'(32'hDEAD_BEEF));
    check("t1_c4_uresp1", 80'(uresp[1]), 80'(0));
    tick();
    dresp = '0;
    ureq[0].valid = 1'b0;
    @(negedge clk);
    check("t1_done_busy", 80'(busy), 80'(0));
    check("t1_done_rr_ptr", 80'(dbg_rr_ptr), 80'(1));

    // Combined addr_ok + data_ok, store on port 1
    tick();
    set_req(1, 32'h8000_0020, 3'd2, 4'hF, 32'h1122_3344);
    tick();
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hCAFE_0001};
    @(negedge clk);
    check("t2_owner", 80'(owner), 80'(1));
    check("t2_strobe", 80'(dreq.strobe), 80'(4'hF));
    check("t2_wdata", 80'(dreq.data), 80'(32'h1122_3344));
    check("t2_uresp1", 80'(uresp[1]), 80'({1'b1, 1'b1, 32'hCAFE_0001}));
    tick();
    dresp = '0;
    ureq[1].valid = 1'b0;
    @(negedge clk);
    check("t2_skip_data_busy", 80'(busy), 80'(0));
    check("t2_rr_ptr", 80'(dbg_rr_ptr), 80'(2));

    // Latched request stays stable while the owner changes/drops ureq
    tick();
    set_req(0, 32'h8000_0010, 3'd2, 4'h0, 32'h0);
    tick();
    dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
    @(negedge clk);
    check("t3_owner", 80'(owner), 80'(0));
    tick();
    dresp = '0;
    ureq[0].addr = 32'h0000_1234;
    @(negedge clk);
    check("t3_addr_stable", 80'(dreq.addr), 80'(32'h8000_0010));
    tick();
    ureq[0].valid = 1'b0;
    @(negedge clk);
    check("t3_drop_valid", 80'(dreq.valid), 80'(1));
    check("t3_drop_addr", 80'(dreq.addr), 80'(32'h8000_0010));
    tick();
    dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h55};
    @(negedge clk);
    check("t3_data_ok", 80'(uresp[0].data_ok), 80'(1));
    tick();
    dresp = '0;
    @(negedge clk);
    check("t3_rr_ptr", 80'(dbg_rr_ptr), 80'(1));

    // Reset in the data phase of a port 2 transaction
    tick();
    set_req(2, 32'h8000_0040, 3'd2, 4'h0, 32'h0);
    tick();
    dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
    tick();
    dresp = '0;
    #1 reset = 1'b1;
    #1;
    check("t4_rst_dreq_valid", 80'(dreq.valid), 80'(0));
    check("t4_rst_busy", 80'(busy), 80'(0));
    check("t4_rst_owner", 80'(owner), 80'(0));
    check("t4_rst_uresp2", 80'(uresp[2]), 80'(0));
    ureq[2] = '0;
    rand_req(0);
    rand_req(1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Contention between ports 0 and 1: alternate grants
    for (int r = 0; r < 8; r++) serve(r % 2, $sformatf("t5_r%0d", r));

    // Ports 1 and 2 with the pointer at 2
    ureq[0].valid = 1'b0;
    rand_req(2);
    serve(2, "t6_a");
    serve(1, "t6_b");
    serve(2, "t6_c");
    for (int i = 0; i < NUM_REQ; i++) ureq[i] = '0;
    check("grant_queue_drained", 80'(exp_q.size()), 80'(0));

    // Randomized traffic, responses and occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (reset) reset = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!ureq[i].valid) begin
          if ($urandom_range(0, 2) == 0) rand_req(i);
        end else if (done_port == i) begin
          if ($urandom_range(0, 1) == 0) ureq[i].valid = 1'b0;
          else rand_req(i);
        end else if ($urandom_range(0, 39) == 0) begin
          ureq[i].valid = 1'b0;
        end
      end
      dresp.addr_ok = 1'($urandom_range(0, 1));
      dresp.data_ok = ($urandom_range(0, 2) == 0);
      dresp.data    = $urandom();
      if ($urandom_range(0, 399) == 0) #1 reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
